// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational ALU: accepts a request, holds the ALU
// operands for an opcode-dependent settle time, then returns the captured result.
module alu_issue_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_incpc,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  output logic        alu_incpc,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        rsp_divz,
  output logic        busy
);

  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   load_n;
  logic               accept;
  logic               req_ok;
  logic               last;
  logic               wide_op;
  logic               div_op;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  always_comb begin
    accept  = req_valid && (state == IDLE);
    req_ok  = req_incpc || is_legal(req_opcode);
    last    = (count == CNT_W'(1));
    div_op  = !alu_incpc && (alu_opcode == OP_DIV);
    wide_op = div_op || (!alu_incpc && (alu_opcode == OP_MUL));
    load_n  = CNT_W'(1);
    if (!req_incpc && req_opcode == OP_MUL)      load_n = CNT_W'(MUL_CYCLES);
    else if (!req_incpc && req_opcode == OP_DIV) load_n = CNT_W'(DIV_CYCLES);
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_ok ? EXEC : RESP;
      EXEC:    if (last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Illegal requests bypass EXEC, so their zeroed response is loaded at accept time.
  always_ff @(posedge clock) begin
    if (clear) begin
      count      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_incpc  <= 1'b0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_err    <= 1'b0;
      rsp_divz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= req_opcode;
            alu_incpc  <= req_incpc;
            count      <= load_n;
            if (!req_ok) begin
              rsp_hi   <= '0;
              rsp_lo   <= '0;
              rsp_err  <= 1'b1;
              rsp_divz <= 1'b0;
            end
          end
        end
        EXEC: begin
          count <= count - CNT_W'(1);
          if (last) begin
            rsp_lo   <= alu_lo;
            rsp_hi   <= wide_op ? alu_hi : '0;
            rsp_divz <= div_op && (alu_b == '0);
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed and randomized bench for alu_issue_seq with a behavioural ALU model
// that only presents the true result on the final settle cycle.
module tb_alu_issue_seq;

  localparam int MULC = 4;
  localparam int DIVC = 8;
  localparam logic [4:0] MUL = 5'b01111;
  localparam logic [4:0] DIV = 5'b10000;
  localparam logic [4:0] LEGAL [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                        5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                        5'b01011, 5'b01111, 5'b10000};

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_incpc = 1'b0;
  logic [4:0]  req_opcode = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic        alu_incpc;
  logic [31:0] alu_hi = '0;
  logic [31:0] alu_lo = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_err, rsp_divz, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_issue_seq #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_incpc(req_incpc),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_incpc(alu_incpc),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .rsp_divz(rsp_divz), .busy(busy)
  );

  function automatic logic is_legal(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                      5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000};
  endfunction

  // Returns {HI, LO} as the settled ALU would; Div gives {remainder, quotient}.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic inc,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    int unsigned sh;
    sh  = int'(b[4:0]);
    dbl = {a, a};
    if (inc) return {32'h0, a + 32'd1};
    case (op)
      5'b00011: return {32'h0, a + b};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a >> sh};
      5'b00110: return {32'h0, 32'($signed(a) >>> sh)};
      5'b00111: return {32'h0, a << sh};
      5'b01000: return {32'h0, 32'(dbl >> sh)};
      5'b01001: return {32'h0, 32'((dbl << sh) >> 32)};
      5'b01010: return {32'h0, a & b};
      5'b01011: return {32'h0, a | b};
      5'b01111: return 64'($signed(a) * $signed(b));
      5'b10000: return (b == 0) ? {32'hDEAD_0000, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full transaction from IDLE to IDLE; bp = cycles rsp_ready is held low,
  // hold = keep presenting junk requests while busy.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic inc, input int bp, input bit hold);
    logic        legal;
    int          n;
    logic [63:0] r;
    logic [31:0] ehi, elo;
    legal = inc || is_legal(op);
    n     = (!inc && op == MUL) ? MULC : (!inc && op == DIV) ? DIVC : 1;
    r     = alu_model(op, inc, a, b);
    elo   = legal ? r[31:0] : 32'h0;
    ehi   = (legal && !inc && (op == MUL || op == DIV)) ? r[63:32] : 32'h0;

    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_opcode = op; req_incpc = inc;
    alu_hi = $urandom; alu_lo = $urandom;
    tick();
    req_valid = hold;
    req_a = $urandom; req_b = $urandom; req_opcode = 5'($urandom); req_incpc = 1'($urandom);
    chk("acc_alu_a", alu_a, a);
    chk("acc_alu_b", alu_b, b);
    chk("acc_alu_op", alu_opcode, op);
    chk("acc_alu_inc", alu_incpc, inc);
    chk("acc_req_ready", req_ready, 0);
    chk("acc_busy", busy, 1);

    if (legal) begin
      for (int k = 1; k <= n; k++) begin
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_hold_a", alu_a, a);
        chk("exec_hold_b", alu_b, b);
        alu_hi = (k == n) ? r[63:32] : $urandom;
        alu_lo = (k == n) ? r[31:0]  : $urandom;
        tick();
      end
    end

    rsp_ready = 1'b0;
    for (int j = 0; j <= bp; j++) begin
      alu_hi = $urandom; alu_lo = $urandom;
      chk("resp_valid", rsp_valid, 1);
      chk("resp_hi", rsp_hi, ehi);
      chk("resp_lo", rsp_lo, elo);
      chk("resp_err", rsp_err, !legal);
      chk("resp_divz", rsp_divz, legal && !inc && op == DIV && b == 0);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_alu_a", alu_a, a);
      if (j < bp) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("done_valid", rsp_valid, 0);
    chk("done_ready", req_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_alu_a_kept", alu_a, a);
  endtask

  initial begin
    logic [4:0] rop;
    int         sel;
    @(negedge clock);
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    clear = 1'b0;

    do_op(32'd5, 32'd7, 5'b00011, 1'b0, 0, 1'b0);
    do_op(32'h0001_0000, 32'h0001_0000, MUL, 1'b0, 1, 1'b0);
    do_op(32'd9, 32'd0, DIV, 1'b0, 0, 1'b0);
    do_op(32'd9, 32'd2, DIV, 1'b0, 0, 1'b0);
    do_op(32'h1234, 32'h5678, 5'b11111, 1'b0, 0, 1'b0);
    do_op(32'h0000_00F0, 32'h0000_000F, 5'b01011, 1'b0, 5, 1'b1);
    do_op(32'h8000_0010, 32'd4, 5'b00110, 1'b0, 0, 1'b0);
    do_op(32'h0000_1000, 32'h0, 5'b11111, 1'b1, 0, 1'b0);

    // Clear during the third EXEC cycle of a Div discards it.
    req_valid = 1'b1; req_a = 32'd9; req_b = 32'd3; req_opcode = DIV; req_incpc = 1'b0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("middiv_busy", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ready", req_ready, 1);
    chk("clr_valid", rsp_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_alu_a", alu_a, 0);
    chk("clr_alu_b", alu_b, 0);
    chk("clr_alu_op", alu_opcode, 0);
    chk("clr_hi", rsp_hi, 0);
    chk("clr_lo", rsp_lo, 0);
    chk("clr_divz", rsp_divz, 0);
    do_op(32'd3, 32'd5, 5'b00100, 1'b0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) rop = LEGAL[$urandom_range(0, 10)];
      else begin
        rop = 5'($urandom);
        while (is_legal(rop)) rop = 5'($urandom);
      end
      do_op($urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, rop,
            (sel == 9) ? 1'($urandom) : 1'b0, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts an operation request over a valid/ready handshake and drives A, B, opcode and IncPC into the combinational ALU.
- Holds the operands stable for an opcode-dependent settle time, then captures C_out_HI/C_out_LO and returns them on a valid/ready response channel.
- Sits between the control unit and the ALU, and replaces ad-hoc Y/Z register strobing for multi-cycle mul/div.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles operands are held for Mul (opcode 01111); minimum 1.
- DIV_CYCLES, 8, number of EXEC cycles for Div (opcode 10000); minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_incpc  in  1  PC-increment request; opcode is ignored when set.
- req_opcode  in  5  ALU opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B (shift/rotate count for shift/rotate ops).
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_opcode  out  5  registered opcode to the ALU.
- alu_incpc  out  1  registered IncPC to the ALU.
- alu_hi  in  32  ALU C_out_HI.
- alu_lo  in  32  ALU C_out_LO.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi  out  32  captured HI result.
- rsp_lo  out  32  captured LO result.
- rsp_err  out  1  illegal opcode.
- rsp_divz  out  1  Div issued with B == 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- **Reset.** When clear is sampled high:
  - state goes to IDLE and the counter goes to 0;
  - alu_a, alu_b, alu_opcode, alu_incpc, rsp_hi, rsp_lo go to 0;
  - rsp_valid, rsp_err, rsp_divz, busy go to 0; req_ready goes to 1.
  - clear overrides every other input. A reset mid-EXEC or mid-RESP discards the operation with no response.
- **Legal opcodes.** 00011 Add, 00100 Sub, 00101 Shr, 00110 Shra, 00111 Shl, 01000 Ror, 01001 Rol, 01010 And, 01011 Or, 01111 Mul, 10000 Div. Any other opcode with req_incpc = 0 is illegal.
- **States.** IDLE, EXEC, RESP. req_ready = (state == IDLE).
- **IDLE.** On req_valid && req_ready at edge t:
  - latch req_a, req_b, req_opcode and req_incpc into the alu_* registers;
  - load the counter with N, where N = 1 for IncPC or single-cycle ops, MUL_CYCLES for Mul, DIV_CYCLES for Div;
  - legal or IncPC request: go to EXEC;
  - illegal opcode: skip EXEC and go directly to RESP with rsp_err = 1 and rsp_hi = rsp_lo = 0; alu_* still updates.
- **EXEC.** The counter decrements each cycle while the alu_* outputs are held constant. At the edge where the counter equals 1:
  - rsp_lo <= alu_lo;
  - rsp_hi <= alu_hi for Mul/Div, otherwise rsp_hi <= 0 (forced, regardless of alu_hi);
  - rsp_divz <= (opcode == Div && alu_b == 0); rsp_err <= 0; then go to RESP.
- **Latency.** Request accepted at edge t, so rsp_valid first asserts after edge t+N. Single-cycle ops show rsp_valid 2 cycles after the accept cycle; illegal opcodes show it 1 cycle after.
- **RESP.**
  - rsp_valid = 1; rsp_hi, rsp_lo, rsp_err and rsp_divz are held stable until rsp_ready is sampled high.
  - When rsp_valid && rsp_ready at an edge: go to IDLE and clear rsp_valid.
  - No new request is accepted in that same cycle, because req_ready is 0 in RESP. Back-to-back throughput is therefore N+2 cycles per operation.
  - The alu_* registers retain their last values until the next accept.
- **Divide by zero.** DIV_CYCLES is still honoured and whatever the ALU produces is captured. rsp_divz only flags the condition.
- **Unused inputs.** req_* is ignored outside IDLE. alu_hi/alu_lo are ignored outside the capture edge.

Test Plan:
- Reset then Add: A=5, B=7, opcode 00011 → req_ready drops next cycle; alu_a=5, alu_b=7 for 1 cycle; rsp_lo=12, rsp_hi=0, rsp_valid 2 cycles after accept; err=0.
- Mul with ALU model: A=0x0001_0000, B=0x0001_0000, opcode 01111, MUL_CYCLES=4 → operands held 4 cycles; rsp_hi=1, rsp_lo=0 after edge t+4. Also check that a model changing alu_* before the final EXEC cycle does not affect the capture.
- Div by zero: A=9, B=0, opcode 10000 → response after 8 EXEC cycles with rsp_divz=1. Then Div 9/2 → rsp_lo=4, rsp_hi=1, rsp_divz=0.
- Illegal opcode 11111 → rsp_valid 1 cycle after accept, rsp_err=1, rsp_hi=rsp_lo=0, no EXEC cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles after an Or with A=0xF0, B=0x0F → rsp_lo=0xFF stable all 5 cycles; req_valid asserted throughout is not accepted until IDLE.
- Reset mid-Div (clear at EXEC cycle 3) → next cycle IDLE, rsp_valid=0, all outputs 0; a subsequent Sub with A=3, B=5 returns rsp_lo=0xFFFF_FFFE.
